// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, credit-limited imem requests, tag queue and instruction FIFO toward decode.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/stall/flush performance counters.
module fetch_stage #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
  logic [XLEN-1:0] tag_q     [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [CW-1:0]   fifo_count, outstanding, drop_cnt;
  logic [CW:0]     credit_used;
  logic            req_fire, rsp_ok, rsp_keep, pop;

  // In-flight requests (including ones to be dropped) plus buffered words may never exceed the FIFO size.
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_ok         = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep       = rsp_ok && (drop_cnt == '0) && !redirect_valid;

  assign inst_valid = !rst && (fifo_count != '0);
  assign inst       = inst_valid ? fifo_data[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr] : '0;
  assign pop        = inst_valid && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
      if (req_fire) begin
        pc     <= pc + XLEN'(4);
        tag_wr <= tag_wr + PW'(1);
      end
      if (rsp_ok)
        tag_rd <= tag_rd + PW'(1);
      // A redirect flushes the buffer; everything still outstanding afterwards becomes a drop.
      if (redirect_valid) begin
        pc         <= redirect_pc & ~XLEN'(3);
        drop_cnt   <= outstanding - CW'(rsp_ok);
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (rsp_ok && (drop_cnt != '0))
          drop_cnt <= drop_cnt - CW'(1);
        if (rsp_keep)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        fifo_count <= fifo_count + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      fifo_data[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= tag_q[tag_rd];
    end
    if (req_fire)
      tag_q[tag_wr] <= pc;
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (req_fire && (perf_fetch_cnt != '1))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (inst_valid && stall && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect_valid && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

  a_rsp_without_request: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: in-order memory model plus a program-order
// reference of which PCs decode must see, with epochs to discard stale responses after redirects.
module tb_fetch_stage;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  fetch_stage #(.XLEN(32), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mem_t;

  mem_t        mem_q[$];
  logic [31:0] exp_q[$];
  mem_t        m;
  logic [31:0] p;
  logic        exp_req;
  logic        prev_rst = 1'b1;
  int          buffered = 0;
  int          epoch = 0;
  int          cyc = 0;
  logic [31:0] model_pc = RPC;
  int          compared = 0;
  int          mismatched = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and reference model: all checks and model updates happen mid-cycle on stable signals.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
      checkOutput("rst_inst", inst, 32'd0);
      checkOutput("rst_inst_pc", inst_pc, 32'd0);
      mem_q.delete();
      exp_q.delete();
      buffered = 0;
      epoch++;
      model_pc = RPC;
    end else begin
`ifdef FETCH_PERF_CNT_EN
      if (prev_rst) begin
        checkOutput("perf_fetch_after_rst", perf_fetch_cnt, 32'd0);
        checkOutput("perf_stall_after_rst", perf_stall_cnt, 32'd0);
        checkOutput("perf_flush_after_rst", perf_flush_cnt, 32'd0);
      end
`endif
      exp_req = !redirect_valid && ((mem_q.size() + buffered) < DEPTH);
      checkOutput("inst_valid", 32'(inst_valid), 32'(buffered > 0));
      checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_req));

      if (inst_valid && !stall) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_inst_pc", inst_pc, 32'hDEAD_BEEF);
        end else begin
          p = exp_q.pop_front();
          checkOutput("inst_pc", inst_pc, p);
          checkOutput("inst_data", inst, memWord(p));
        end
        if (buffered > 0) buffered--;
      end

      if (imem_rsp_valid && mem_q.size() > 0) begin
        m = mem_q.pop_front();
        if (m.epoch == epoch && !redirect_valid) buffered++;
      end

      if (imem_req_valid && imem_req_ready) begin
        checkOutput("req_addr", imem_req_addr, model_pc);
        mem_q.push_back('{addr: imem_req_addr, epoch: epoch, due: cyc + 1});
        exp_q.push_back(model_pc);
        model_pc = model_pc + 32'd4;
      end

      if (redirect_valid) begin
        epoch++;
        exp_q.delete();
        buffered = 0;
        model_pc = {redirect_pc[31:2], 2'b00};
      end
    end
    prev_rst = rst;
  end

  // Drives one cycle of inputs; the memory answers the oldest pending request with probability rsp_pct.
  task automatic applyStimulus(input logic r, input logic rdy, input logic st, input logic rv,
                               input logic [31:0] rpc, input int rsp_pct);
    rst            = r;
    imem_req_ready = rdy;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!r && mem_q.size() > 0 && mem_q[0].due <= cyc && int'($urandom_range(99)) < rsp_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memWord(mem_q[0].addr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(posedge clk);
    #1;
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0);

    $display("[TB] streaming from reset PC");
    repeat (20) applyStimulus(0, 1, 0, 0, 0, 100);

    $display("[TB] stall holds head and exhausts credit");
    repeat (5) applyStimulus(0, 1, 1, 0, 0, 100);
    repeat (10) applyStimulus(0, 1, 0, 0, 0, 100);

    $display("[TB] redirect with two responses in flight");
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 100);
    repeat (3) applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 32'h0000_2002, 100);
    repeat (12) applyStimulus(0, 1, 0, 0, 0, 100);

    $display("[TB] PC wrap-around");
    applyStimulus(0, 1, 0, 1, 32'hFFFF_FFF2, 100);
    repeat (14) applyStimulus(0, 1, 0, 0, 0, 100);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(0, ($urandom_range(99) < 70), ($urandom_range(99) < 30),
                    ($urandom_range(99) < 3), $urandom, 60);
    end

    $display("[TB] reset with full FIFO");
    repeat (6) applyStimulus(0, 1, 1, 0, 0, 100);
    applyStimulus(1, 1, 1, 0, 0, 100);
    repeat (15) applyStimulus(0, 1, 0, 0, 0, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
